cmd_dispatch: RTL and testbench

- Parametrised command dispatcher and response collector; next generation of the single-target command/response FIFO controller.
- Pops one command word from the command FIFO and decodes its target field. Runs one of N_TGT target executors (TAP, registers, etc.) and writes that target's response word to the response FIFO.
- Adds what the single-target version lacks: multiple targets, an execute timeout, error responses for bad target or timeout, back-pressure on the response FIFO (waits, never drops), and an error counter.

---
 rtl/cmd_dispatch.sv | 146 ++++++++++++++
 tb/tb_cmd_dispatch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch.sv
// Command dispatcher: pops a command, runs one of N_TGT targets,
// and writes its response (or an error word) to the response FIFO.
module cmd_dispatch #(
  parameter int          DATA_W  = 32,
  parameter int          N_TGT   = 4,
  parameter int          TGT_LSB = 24,
  parameter int          TIMEOUT = 1023,
  parameter logic [7:0]  ERR_TAG = 8'hEE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       cmd_data,
  input  logic                    cmd_waitreq,
  output logic                    cmd_rdreq,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    rsp_waitreq,
  output logic                    rsp_wrreq,
  output logic [DATA_W-1:0]       tgt_cmd,
  output logic [N_TGT-1:0]        tgt_run,
  input  logic [N_TGT-1:0]        tgt_done,
  input  logic [N_TGT*DATA_W-1:0] tgt_rsp,
  output logic                    busy,
  output logic [15:0]             err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_DECODE,
    S_EXE,
    S_WR_RSP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_sel;
  logic [15:0]       r_cnt;
  logic [DATA_W-1:0] r_tgt_cmd;
  logic [DATA_W-1:0] r_rsp;
  logic [15:0]       r_err;

  logic [3:0]        w_field;
  logic              w_bad;
  logic              w_done;
  logic              w_timeout;
  logic              w_err_inc;
  logic [DATA_W-1:0] w_rsp;
  logic [N_TGT-1:0]  w_hot;

  function automatic logic [DATA_W-1:0] f_err(
    input logic [DATA_W-1:0] c,
    input logic              to,
    input logic              bad
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[DATA_W-1 -: 8] = ERR_TAG;
    w[17] = to;
    w[16] = bad;
    w[15:0] = c[15:0];
    return w;
  endfunction

  assign w_field   = r_tgt_cmd[TGT_LSB+3:TGT_LSB];
  assign w_bad     = int'({28'd0, w_field}) >= N_TGT;
  assign w_timeout = r_cnt == 16'(TIMEOUT-1);

  // Only the selected target's done/response is ever looked at
  always_comb begin
    w_done = 1'b0;
    w_rsp  = '0;
    w_hot  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (r_sel == 4'(i)) begin
        w_done   = tgt_done[i];
        w_rsp    = tgt_rsp[i*DATA_W +: DATA_W];
        w_hot[i] = 1'b1;
      end
    end
  end

  assign w_err_inc = (r_state == S_DECODE && w_bad) ||
                     (r_state == S_EXE && !w_done && w_timeout);

  always_comb begin
    w_next    = r_state;
    cmd_rdreq = 1'b0;
    rsp_wrreq = 1'b0;
    tgt_run   = '0;
    busy      = r_state != S_IDLE;
    unique case (r_state)
      S_IDLE: begin
        if (!cmd_waitreq) w_next = S_RD_CMD;
      end
      S_RD_CMD: begin
        cmd_rdreq = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        w_next = w_bad ? S_WR_RSP : S_EXE;
      end
      S_EXE: begin
        tgt_run = w_hot;
        if (w_done || w_timeout) w_next = S_WR_RSP;
      end
      S_WR_RSP: begin
        rsp_wrreq = !rsp_waitreq;
        if (!rsp_waitreq) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_tgt_cmd <= '0;
      r_rsp     <= '0;
      r_err     <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_RD_CMD: r_tgt_cmd <= cmd_data;
        S_DECODE: begin
          r_sel <= w_field;
          if (w_bad) r_rsp <= f_err(r_tgt_cmd, 1'b0, 1'b1);
          else       r_cnt <= '0;
        end
        S_EXE: begin
          if (w_done)         r_rsp <= w_rsp;
          else if (w_timeout) r_rsp <= f_err(r_tgt_cmd, 1'b1, 1'b0);
          else                r_cnt <= r_cnt + 16'd1;
        end
        default: ;
      endcase
      if (w_err_inc && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
    end
  end

  assign rsp_data = r_rsp;
  assign tgt_cmd  = r_tgt_cmd;
  assign err_cnt  = r_err;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized bench for cmd_dispatch with a transaction-level model
// that predicts every output cycle by cycle from command timing rules.
module tb_cmd_dispatch;
  localparam int DW = 32;
  localparam int NT = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   cmd_data;
  logic            cmd_waitreq;
  logic            cmd_rdreq;
  logic [DW-1:0]   rsp_data;
  logic            rsp_waitreq;
  logic            rsp_wrreq;
  logic [DW-1:0]   tgt_cmd;
  logic [NT-1:0]   tgt_run;
  logic [NT-1:0]   tgt_done;
  logic [NT*DW-1:0] tgt_rsp;
  logic            busy;
  logic [15:0]     err_cnt;

  always #5 clk = ~clk;

  cmd_dispatch #(
    .DATA_W (DW),
    .N_TGT  (NT),
    .TGT_LSB(24),
    .TIMEOUT(TO),
    .ERR_TAG(8'hEE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_data   (cmd_data),
    .cmd_waitreq(cmd_waitreq),
    .cmd_rdreq  (cmd_rdreq),
    .rsp_data   (rsp_data),
    .rsp_waitreq(rsp_waitreq),
    .rsp_wrreq  (rsp_wrreq),
    .tgt_cmd    (tgt_cmd),
    .tgt_run    (tgt_run),
    .tgt_done   (tgt_done),
    .tgt_rsp    (tgt_rsp),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  // d: EXE cycle index in which the target raises done (>= TO means never)
  typedef struct {
    logic [31:0] cmd;
    int          d;
    logic [31:0] val;
    int          hold;
    bit          has_lit;
    logic [31:0] lit;
    int          lit_err;
    int          gap;
    int          rst_at;
  } plan_t;

  plan_t pq[$];
  plan_t cur;
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic plan_t mk(logic [31:0] c, int d, logic [31:0] v,
                               int hold, bit hl, logic [31:0] lit,
                               int le, int gap, int ra);
    plan_t p;
    p.cmd = c; p.d = d; p.val = v; p.hold = hold;
    p.has_lit = hl; p.lit = lit; p.lit_err = le;
    p.gap = gap; p.rst_at = ra;
    return p;
  endfunction

  function automatic logic [31:0] errw(logic [31:0] c, bit to, bit bad);
    return {8'hEE, 6'd0, to, bad, c[15:0]};
  endfunction

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  initial begin
    bit          act, ready, rst_pend, just_rst;
    bit          valid, inwin, is_err, exp_rd, exp_wr, exp_busy;
    int          sr, errc, n_rand, last_rd, len, ws, s, exp_err;
    logic [3:0]  sel;
    logic [3:0]  exp_run;
    logic [31:0] exp_rsp;
    plan_t       p;

    rst = 1'b1;
    cmd_data = '0;
    cmd_waitreq = 1'b1;
    rsp_waitreq = 1'b0;
    tgt_done = '0;
    tgt_rsp = '0;

    pq.push_back(mk(32'h0100_1234, 1, 32'hCAFE_0001, 0, 1, 32'hCAFE_0001, 0, 0, -1));
    pq.push_back(mk(32'h0700_ABCD, 0, 32'h0, 0, 1, 32'hEE01_ABCD, 1, 0, -1));
    pq.push_back(mk(32'h0200_5678, 100, 32'h0, 0, 1, 32'hEE02_5678, 2, 0, -1));
    pq.push_back(mk(32'h0300_0042, 7, 32'h1234_5678, 0, 1, 32'h1234_5678, 2, 0, -1));
    pq.push_back(mk(32'h0000_BEEF, 2, 32'hAAAA_5555, 20, 1, 32'hAAAA_5555, 2, 0, -1));
    pq.push_back(mk(32'h0000_0001, 0, 32'h1111_0000, 0, 1, 32'h1111_0000, -1, 0, -1));
    pq.push_back(mk(32'h0300_0002, 0, 32'h2222_0000, 0, 1, 32'h2222_0000, -1, 5, -1));
    pq.push_back(mk(32'h0000_0003, 0, 32'h3333_0000, 0, 1, 32'h3333_0000, -1, 5, -1));
    pq.push_back(mk(32'h0100_0777, 100, 32'h0, 0, 0, 32'h0, -1, 0, 3));
    pq.push_back(mk(32'h0200_0009, 1, 32'h0000_5A5A, 0, 1, 32'h0000_5A5A, 0, 0, -1));

    repeat (2) @(posedge clk);

    act = 0; ready = 0; rst_pend = 1; sr = 0; errc = 0;
    n_rand = 0; last_rd = -100; cur = pq[0];

    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      just_rst = rst_pend;
      if (rst_pend) begin
        act = 0; errc = 0; rst_pend = 0;
      end

      if (pq.size() == 0 && n_rand < 300 && $urandom_range(0, 2) == 0) begin
        p = mk({4'($urandom), 4'($urandom_range(0, 5)), 24'($urandom)},
               int'($urandom_range(0, 11)), $urandom, -1, 0, 32'h0, -1, 0, -1);
        pq.push_back(p);
        n_rand++;
      end

      exp_rd = 0;
      if (!act && ready) begin
        act = 1; sr = 0; cur = pq.pop_front(); exp_rd = 1;
      end else if (act) begin
        sr++;
      end

      sel     = cur.cmd[27:24];
      s       = int'(sel);
      valid   = s < NT;
      len     = valid ? ((cur.d + 1 < TO) ? cur.d + 1 : TO) : 0;
      ws      = 2 + len;
      inwin   = act && sr >= ws;
      is_err  = !valid || cur.d >= TO;
      exp_rsp = !valid ? errw(cur.cmd, 0, 1)
              : (cur.d < TO ? cur.val : errw(cur.cmd, 1, 0));
      exp_run = (act && valid && sr >= 2 && sr < ws) ? (4'b0001 << s) : 4'b0000;

      if (inwin)
        rsp_waitreq = (cur.hold >= 0) ? (sr - ws < cur.hold)
                                      : ($urandom_range(0, 2) == 0);
      else
        rsp_waitreq = 1'($urandom);
      exp_wr = inwin && !rsp_waitreq;

      tgt_done = 4'($urandom);
      if (act && valid && sr >= 2 && sr < ws)
        tgt_done[s] = (sr - 2 == cur.d);
      if (act && sr == 0) begin
        tgt_rsp = {$urandom, $urandom, $urandom, $urandom};
        if (valid) tgt_rsp[s*32 +: 32] = cur.val;
      end

      if (act && sr == 0) begin
        cmd_data = cur.cmd; cmd_waitreq = 1'b0;
      end else if (pq.size() > 0) begin
        cmd_data = pq[0].cmd; cmd_waitreq = 1'b0;
      end else begin
        cmd_data = $urandom; cmd_waitreq = 1'b1;
      end

      exp_err  = (inwin && is_err) ? sat(errc) : errc;
      exp_busy = act;
      if (act && cur.rst_at >= 0 && sr == 2 + cur.rst_at) rst = 1'b1;

      @(negedge clk);
      chk("cmd_rdreq", 32'(cmd_rdreq), 32'(exp_rd));
      chk("tgt_run", 32'(tgt_run), 32'(exp_run));
      chk("rsp_wrreq", 32'(rsp_wrreq), 32'(exp_wr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("err_cnt", 32'(err_cnt), exp_err);
      if (inwin) chk("rsp_data", rsp_data, exp_rsp);
      if (act && sr >= 1) chk("tgt_cmd", tgt_cmd, cur.cmd);
      if (just_rst) begin
        chk("rsp_data_rst", rsp_data, 32'h0);
        chk("tgt_cmd_rst", tgt_cmd, 32'h0);
      end
      if (exp_rd) begin
        if (cur.gap > 0) chk("loop_cycles", 32'(cyc - last_rd), 32'(cur.gap));
        last_rd = cyc;
      end
      if (exp_wr) begin
        if (cur.has_lit) chk("rsp_literal", rsp_data, cur.lit);
        if (cur.lit_err >= 0) chk("err_literal", 32'(err_cnt), 32'(cur.lit_err));
        errc = exp_err;
        act = 0;
      end

      ready = !exp_busy && !cmd_waitreq && !rst;
      if (rst) rst_pend = 1;
      if (n_rand >= 300 && pq.size() == 0 && !act && !rst_pend) break;
    end

    chk("drain", 32'(pq.size()) + 32'(act), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
